// File: rtl/cache_ctrl.sv
// Direct-mapped write-back cache controller: 8 lines x 16 bytes.
// Ports: processor req/resp, memory req/resp, tag/data array, stats.
// Optional hit/miss counters are enabled with CACHE_CTRL_STATS_EN.
module cache_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         cachereq_val,
  output logic         cachereq_rdy,
  input  logic         cachereq_type,
  input  logic [31:0]  cachereq_addr,
  input  logic [31:0]  cachereq_data,
  output logic         cacheresp_val,
  input  logic         cacheresp_rdy,
  output logic [31:0]  cacheresp_data,
  output logic         memreq_val,
  input  logic         memreq_rdy,
  output logic         memreq_type,
  output logic [31:0]  memreq_addr,
  output logic [127:0] memreq_data,
  input  logic         memresp_val,
  output logic         memresp_rdy,
  input  logic [127:0] memresp_data,
  output logic [2:0]   addr,
  output logic         tag_read_en,
  output logic         tag_write_en,
  output logic [31:0]  tag_write_data,
  input  logic [31:0]  tag_read_data,
  output logic         data_read_en,
  output logic         data_write_en,
  output logic [15:0]  data_write_byte_en,
  output logic [127:0] data_write_data,
  input  logic [127:0] data_read_data,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  typedef enum logic [2:0] {
    IDLE, TAG_CHECK, EVICT_REQ, EVICT_WAIT,
    REFILL_REQ, REFILL_WAIT, RESP
  } state_e;

  state_e      state_q, state_d;
  logic        type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] resp_q, resp_d;
  logic [7:0]  valid_q, valid_d;
  logic [7:0]  dirty_q, dirty_d;
  logic        replay_q, replay_d;

  logic [2:0]  idx;
  logic [24:0] tag;
  logic [1:0]  word;
  logic        hit;

  assign idx  = addr_q[6:4];
  assign tag  = addr_q[31:7];
  assign word = addr_q[3:2];
  assign hit  = valid_q[idx] && (tag_read_data[24:0] == tag);

  assign addr           = idx;
  assign cacheresp_data = resp_q;

  always_comb begin
    state_d            = state_q;
    type_d             = type_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    resp_d             = resp_q;
    valid_d            = valid_q;
    dirty_d            = dirty_q;
    replay_d           = replay_q;
    cachereq_rdy       = 1'b0;
    cacheresp_val      = 1'b0;
    memreq_val         = 1'b0;
    memreq_type        = 1'b0;
    memreq_addr        = '0;
    memreq_data        = '0;
    memresp_rdy        = 1'b0;
    tag_read_en        = 1'b0;
    tag_write_en       = 1'b0;
    tag_write_data     = '0;
    data_read_en       = 1'b0;
    data_write_en      = 1'b0;
    data_write_byte_en = '0;
    data_write_data    = '0;
    unique case (state_q)
      IDLE: begin
        cachereq_rdy = 1'b1;
        if (cachereq_val) begin
          type_d   = cachereq_type;
          addr_d   = cachereq_addr;
          wdata_d  = cachereq_data;
          replay_d = 1'b0;
          state_d  = TAG_CHECK;
        end
      end
      TAG_CHECK: begin
        tag_read_en  = 1'b1;
        data_read_en = 1'b1;
        if (hit) begin
          state_d = RESP;
          if (type_q) begin
            data_write_en      = 1'b1;
            data_write_byte_en = 16'h000F << {word, 2'b00};
            data_write_data    = {4{wdata_q}};
            dirty_d[idx]       = 1'b1;
            resp_d             = '0;
          end else begin
            resp_d = data_read_data[{word, 5'b0} +: 32];
          end
        end else if (valid_q[idx] && dirty_q[idx]) begin
          state_d = EVICT_REQ;
        end else begin
          state_d = REFILL_REQ;
        end
      end
      EVICT_REQ: begin
        tag_read_en  = 1'b1;
        data_read_en = 1'b1;
        memreq_val   = 1'b1;
        memreq_type  = 1'b1;
        memreq_addr  = {tag_read_data[24:0], idx, 4'b0};
        memreq_data  = data_read_data;
        if (memreq_rdy) state_d = EVICT_WAIT;
      end
      EVICT_WAIT: begin
        memresp_rdy = 1'b1;
        if (memresp_val) state_d = REFILL_REQ;
      end
      REFILL_REQ: begin
        memreq_val  = 1'b1;
        memreq_addr = {addr_q[31:4], 4'b0};
        if (memreq_rdy) state_d = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        memresp_rdy = 1'b1;
        if (memresp_val) begin
          tag_write_en       = 1'b1;
          tag_write_data     = {7'b0, tag};
          data_write_en      = 1'b1;
          data_write_byte_en = 16'hFFFF;
          data_write_data    = memresp_data;
          valid_d[idx]       = 1'b1;
          dirty_d[idx]       = 1'b0;
          replay_d           = 1'b1;
          state_d            = TAG_CHECK;
        end
      end
      RESP: begin
        cacheresp_val = 1'b1;
        if (cacheresp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      type_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      replay_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      resp_q   <= resp_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      replay_q <= replay_d;
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_q, miss_q;
  logic        lookup;

  // The post-refill pass through TAG_CHECK is not a new lookup.
  assign lookup = (state_q == TAG_CHECK) && !replay_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (lookup) begin
      if (hit) hit_q <= hit_q + 32'd1;
      else     miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  logic unused_replay;
  assign unused_replay = replay_q;
  assign hit_count     = '0;
  assign miss_count    = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{addr_q[1:0], tag_read_data[31:25]};

endmodule
